mem_slave_wait: RTL and testbench

//  Single-port memory target on the valid/ready request bus (addr, wdata, wr_rd, valid -> ready, rdata).

---
 rtl/mem_slave_wait.sv | 128 ++++++++++++
 tb/tb_mem_slave_wait.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_slave_wait.sv
// Single-port memory target with parameterised read/write wait states and an rvalid read strobe.
// Define MEM_OOR_ERR_EN to raise a one-cycle err strobe on out-of-range completions.
module mem_slave_wait #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64,
  parameter int RD_LAT     = 2,
  parameter int WR_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  wr_rd,
  input  logic                  valid,
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  output logic                  err
);

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("mem_slave_wait: RD_LAT must be in 1..15");
  end
  if (WR_LAT < 1 || WR_LAT > 15) begin : g_bad_wr_lat
    $error("mem_slave_wait: WR_LAT must be in 1..15");
  end
  if (DEPTH < 1 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
    $error("mem_slave_wait: DEPTH must be in 1..2**ADDR_WIDTH");
  end

  localparam logic [3:0]            RD_CNT  = 4'(RD_LAT - 1);
  localparam logic [3:0]            WR_CNT  = 4'(WR_LAT - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam int                    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  // state is kept as a named signal so checkers can bind to it directly.
  state_t                 state, state_next;
  logic [3:0]             cnt, cnt_next;
  logic                   ready_next;
  logic                   accept, complete, in_range;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [WIDTH-1:0]       wdata_q;
  logic                   wr_q;
  logic [IDX_W-1:0]       mem_idx;
  logic [WIDTH-1:0]       mem [DEPTH];

  // Handshake: a request transfers on the rising edge where valid && ready;
  // while ready=0 the request inputs are ignored and nothing is queued.
  assign accept   = valid && ready;
  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  assign mem_idx  = addr_q[IDX_W-1:0];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ready_next = ready;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        ready_next = 1'b1;
        if (accept) begin
          state_next = BUSY;
          cnt_next   = wr_rd ? WR_CNT : RD_CNT;
          ready_next = 1'b0;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          complete   = 1'b1;
          state_next = IDLE;
          ready_next = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ready   <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      ready  <= ready_next;
      rvalid <= complete && !wr_q;
      if (complete && !wr_q) begin
        rdata <= in_range ? mem[mem_idx] : '0;
      end
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        wr_q    <= wr_rd;
      end
    end
  end

  // The array has no reset; an abort by rst suppresses the pending write.
  always_ff @(posedge clk) begin
    if (!rst && complete && wr_q && in_range) begin
      mem[mem_idx] <= wdata_q;
    end
  end

`ifdef MEM_OOR_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= complete && !in_range;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_slave_wait.sv
// Self-checking bench for mem_slave_wait (DEPTH=40, RD_LAT=2, WR_LAT=1) with a read-data scoreboard.
// Honours MEM_OOR_ERR_EN when deciding the expected err strobe.
module tb_mem_slave_wait;

  localparam int W  = 16;
  localparam int AW = 6;
  localparam int DP = 40;
`ifdef MEM_OOR_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [W-1:0]  wdata = '0;
  logic          wr_rd = 1'b0;
  logic          valid = 1'b0;
  logic          ready;
  logic [W-1:0]  rdata;
  logic          rvalid;
  logic          err;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  model [64];
  int            n_checks = 0;
  int            n_fail = 0;

  mem_slave_wait #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(DP), .RD_LAT(2), .WR_LAT(1)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wr_rd(wr_rd),
    .valid(valid), .ready(ready), .rdata(rdata), .rvalid(rvalid), .err(err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard: every rvalid pops one expected read result
  task automatic monitor_loop;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rvalid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rvalid_unexpected: rdata=%h with no read outstanding", rdata);
        end else begin
          e = exp_q.pop_front();
          if (rdata !== e) begin
            n_fail++;
            $display("FAIL rdata: got %h expected %h", rdata, e);
          end
        end
      end
    end
  endtask

  // driver tasks
  task automatic wait_ready;
    int t = 0;
    while (ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", ready, t);
    end
  endtask

  task automatic drain;
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d reads outstanding, required 0", exp_q.size());
    end
    wait_ready();
  endtask

  // Returns at the negedge right after the accept edge.
  task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d);
    wait_ready();
    wr_rd = wr;
    addr  = a;
    wdata = d;
    valid = 1'b1;
    if (wr) begin
      if (a < DP) model[a] = d;
    end else begin
      exp_q.push_back((a < DP) ? model[a] : '0);
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b0 || rvalid !== 1'b0 || err !== 1'b0 || rdata !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: ready=%b rvalid=%b err=%b rdata=%h, required 0 0 0 0",
                 ready, rvalid, err, rdata);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: ready=%b required 1", ready);
    end
  endtask

  task automatic test_write_read;
    do_req(1'b1, 6'd5, 16'hA5A5);
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_busy_ready: ready=%b required 0", ready);
    end
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_done_ready: ready=%b required 1", ready);
    end
    do_req(1'b0, 6'd5, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (ready !== 1'b0 || rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_busy_%0d: ready=%b rvalid=%b required 0 0", i, ready, rvalid);
      end
      @(negedge clk);
    end
    n_checks++;
    if (ready !== 1'b1 || rvalid !== 1'b1 || rdata !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL rd_done: ready=%b rvalid=%b rdata=%h required 1 1 a5a5", ready, rvalid, rdata);
    end
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b0 || rdata !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL rd_strobe_hold: rvalid=%b rdata=%h required 0 a5a5", rvalid, rdata);
    end
    drain();
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    int gap, lat;
    wait_ready();
    for (int k = 0; k < 16; k++) begin
      a     = AW'((k / 2) % 4);
      d     = W'($urandom_range(0, 65535));
      wr_rd = (k % 2 == 0);
      addr  = a;
      wdata = d;
      valid = 1'b1;
      if (k % 2 == 0) model[a] = d;
      else exp_q.push_back(model[a]);
      lat = (k % 2 == 0) ? 1 : 2;
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (ready !== 1'b1 && gap < 20);
      n_checks++;
      if (gap != lat + 1) begin
        n_fail++;
        $display("FAIL b2b_gap[%0d]: accept spacing %0d cycles, required %0d", k, gap, lat + 1);
      end
    end
    valid = 1'b0;
    drain();
  endtask

  task automatic test_ignore_busy;
    do_req(1'b1, 6'd2, 16'h5A5A);
    wr_rd = 1'b1; addr = 6'd2; wdata = 16'hFFFF; valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_wr_ready: ready=%b required 1", ready);
    end
    valid = 1'b0;
    do_req(1'b0, 6'd2, 16'h0000);
    wr_rd = 1'b1; addr = 6'd3; wdata = 16'h0BAD; valid = 1'b1;
    @(negedge clk);
    addr = 6'd1; wdata = 16'hDEAD;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_rd_done: ready=%b rvalid=%b required 1 1", ready, rvalid);
    end
    valid = 1'b0;
    drain();
    do_req(1'b0, 6'd3, 16'h0000);
    do_req(1'b0, 6'd1, 16'h0000);
    drain();
  endtask

  task automatic test_reset_abort;
    do_req(1'b1, 6'd7, 16'h1234);
    wait_ready();
    wr_rd = 1'b1; addr = 6'd7; wdata = 16'hFFFF; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b0 || rvalid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_reset: ready=%b rvalid=%b err=%b required 0 0 0", ready, rvalid, err);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || rvalid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_release: ready=%b rvalid=%b err=%b required 1 0 0", ready, rvalid, err);
    end
    do_req(1'b0, 6'd7, 16'h0000);
    drain();
  endtask

  task automatic test_out_of_range;
    do_req(1'b1, 6'd45, 16'hBEEF);
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || err !== EXP_ERR) begin
      n_fail++;
      $display("FAIL oor_wr_err: ready=%b err=%b required 1 %b", ready, err, EXP_ERR);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_err_pulse: err=%b required 0", err);
    end
    do_req(1'b0, 6'd45, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== '0 || err !== EXP_ERR) begin
      n_fail++;
      $display("FAIL oor_rd: rvalid=%b rdata=%h err=%b required 1 0000 %b", rvalid, rdata, err, EXP_ERR);
    end
    do_req(1'b0, 6'd5, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL inrange_rd_err: rvalid=%b err=%b required 1 0", rvalid, err);
    end
    do_req(1'b1, 6'd39, 16'h3939);
    do_req(1'b0, 6'd39, 16'h0000);
    do_req(1'b1, 6'd40, 16'h4040);
    do_req(1'b0, 6'd40, 16'h0000);
    do_req(1'b0, 6'd63, 16'h0000);
    do_req(1'b0, 6'd0, 16'h0000);
    drain();
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    test_reset();
    test_write_read();
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
    test_out_of_range();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
